// File: rtl/cpu86_exec_trace_serializer.sv
// Buffers CPU86 execution-unit register snapshots in a small FIFO and streams
// each one out as a 26-byte frame: A5, op, code, 11 registers (low byte first), checksum.
module cpu86_exec_trace_serializer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_en,
  input  logic                     vld_valid,
  input  logic [4:0]               vld_op,
  input  logic [3:0]               vld_code,
  input  logic [15:0]              vld_cs,
  input  logic [15:0]              vld_ip,
  input  logic [15:0]              vld_ax,
  input  logic [15:0]              vld_bx,
  input  logic [15:0]              vld_cx,
  input  logic [15:0]              vld_dx,
  input  logic [15:0]              vld_bp,
  input  logic [15:0]              vld_sp,
  input  logic [15:0]              vld_si,
  input  logic [15:0]              vld_di,
  input  logic [15:0]              vld_fl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_cnt,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 185;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [EW-1:0]   frame_q, frame_d;
  logic [7:0]      sum_q, sum_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]     drop_q, drop_d;
  logic [EW-1:0]   mem [DEPTH];

  logic            empty, full, push_req, push, pop, last_acc;
  logic [EW-1:0]   wr_entry, head;
  logic [7:0]      frame_byte;
  logic [4:0]      rel;
  logic [15:0]     regs [11];
  logic [15:0]     word;

  assign wr_entry = {vld_op, vld_code, vld_cs, vld_ip, vld_ax, vld_bx, vld_cx,
                     vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl};
  assign head     = mem[rd_ptr_q[AW-1:0]];

  // The extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign last_acc = (state_q == SEND) && out_ready && (idx_q == 5'd25);
  assign pop      = !empty && ((state_q == IDLE) || last_acc);
  assign push_req = vld_valid && trace_en;
  assign push     = push_req && (!full || pop);

  // Register field k of the frame sits at bytes 3+2k (low) and 4+2k (high).
  for (genvar g = 0; g < 11; g++) begin : g_regs
    assign regs[g] = frame_q[175-16*g -: 16];
  end
  assign rel  = idx_q - 5'd3;
  assign word = regs[rel[4:1]];

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      5'd0:    frame_byte = 8'hA5;
      5'd1:    frame_byte = {3'b000, frame_q[184:180]};
      5'd2:    frame_byte = {4'b0000, frame_q[179:176]};
      5'd25:   frame_byte = 8'h00 - sum_q;
      default: frame_byte = rel[0] ? word[15:8] : word[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    drop_d   = drop_q;
    if (push_req && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (pop) begin
          frame_d = head;
          idx_d   = 5'd0;
          sum_d   = 8'h00;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == 5'd25) begin
            idx_d = 5'd0;
            sum_d = 8'h00;
            if (pop) frame_d = head;
            else     state_d = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
            if (idx_q != 5'd0) sum_d = sum_q + frame_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 5'd0;
      frame_q  <= '0;
      sum_q    <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      sum_q    <= sum_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign out_valid  = (state_q == SEND);
  assign out_data   = (state_q == SEND) ? frame_byte : 8'h00;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign drop_cnt   = drop_q;
  assign busy       = (state_q == SEND) || !empty;

endmodule

// File: tb/tb_cpu86_exec_trace_serializer.sv
// Bench for the trace serializer: directed scenarios plus a random sweep, all
// checked every cycle against a queue-based model of snapshots and frames.
module tb_cpu86_exec_trace_serializer;
  localparam int DEPTH = 4;

  logic        clk, rst, trace_en, vld_valid, out_ready;
  logic [4:0]  vld_op;
  logic [3:0]  vld_code;
  logic [15:0] vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx;
  logic [15:0] vld_bp, vld_sp, vld_si, vld_di, vld_fl;
  logic        out_valid, busy;
  logic [7:0]  out_data;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;

  cpu86_exec_trace_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .vld_valid(vld_valid),
    .vld_op(vld_op), .vld_code(vld_code), .vld_cs(vld_cs), .vld_ip(vld_ip),
    .vld_ax(vld_ax), .vld_bx(vld_bx), .vld_cx(vld_cx), .vld_dx(vld_dx),
    .vld_bp(vld_bp), .vld_sp(vld_sp), .vld_si(vld_si), .vld_di(vld_di),
    .vld_fl(vld_fl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: pending snapshots, frame in flight, drop count
  logic [184:0] m_fifo[$];
  logic [7:0]   m_frame[26];
  bit           m_active;
  int           m_idx;
  int           m_drop;

  // receive side
  logic [7:0]   rx_bytes[26];
  logic [7:0]   rx_sum;
  int           rx_pos;
  int           frames_rx;
  bit           prev_stall;
  logic [7:0]   prev_data;
  int           cyc;

  function automatic void load_frame(input logic [184:0] s);
    logic [175:0] regs;
    logic [15:0]  w;
    logic [7:0]   sum;
    regs = s[175:0];
    sum  = 8'h00;
    m_frame[0] = 8'hA5;
    m_frame[1] = {3'b000, s[184:180]};
    m_frame[2] = {4'b0000, s[179:176]};
    for (int r = 0; r < 11; r++) begin
      w = regs[175:160];
      m_frame[3+2*r] = w[7:0];
      m_frame[4+2*r] = w[15:8];
      regs = regs << 16;
    end
    for (int k = 1; k < 25; k++) sum = sum + m_frame[k];
    m_frame[25] = 8'h00 - sum;
  endfunction

  function automatic logic [184:0] rand_snap();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[184:0];
  endfunction

  // driver tasks
  task automatic set_snap(input logic [184:0] s);
    {vld_op, vld_code, vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx,
     vld_bp, vld_sp, vld_si, vld_di, vld_fl} = s;
  endtask

  task automatic clear_model();
    m_fifo.delete();
    m_active   = 1'b0;
    m_idx      = 0;
    m_drop     = 0;
    rx_pos     = 0;
    rx_sum     = 8'h00;
    prev_stall = 1'b0;
  endtask

  // Called at a falling edge: check outputs, then advance the model with the
  // inputs the DUT will sample on the coming rising edge.
  task automatic tick();
    bit do_pop, push_req, accept;
    logic [184:0] snap;
    check_eq("out_valid", out_valid, m_active);
    if (m_active) check_eq("out_data", out_data, m_frame[m_idx]);
    check_eq("fifo_level", fifo_level, m_fifo.size());
    check_eq("drop_cnt", drop_cnt, m_drop);
    check_eq("busy", busy, m_active || (m_fifo.size() != 0));
    if (prev_stall) check_eq("hold_data", out_data, prev_data);
    if (out_valid && out_ready) begin
      rx_bytes[rx_pos] = out_data;
      if (rx_pos > 0) rx_sum = rx_sum + out_data;
      if (rx_pos == 25) begin
        check_eq("frame_sum", rx_sum, 0);
        frames_rx++;
        rx_pos = 0;
        rx_sum = 8'h00;
      end else begin
        rx_pos++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;

    snap     = {vld_op, vld_code, vld_cs, vld_ip, vld_ax, vld_bx, vld_cx,
                vld_dx, vld_bp, vld_sp, vld_si, vld_di, vld_fl};
    do_pop   = (m_fifo.size() > 0) && (!m_active || (out_ready && m_idx == 25));
    push_req = vld_valid && trace_en;
    accept   = push_req && ((m_fifo.size() < DEPTH) || do_pop);
    if (m_active && out_ready) begin
      if (m_idx == 25) m_active = 1'b0;
      else             m_idx++;
    end
    if (do_pop) begin
      load_frame(m_fifo.pop_front());
      m_idx    = 0;
      m_active = 1'b1;
    end
    if (accept) m_fifo.push_back(snap);
    else if (push_req && m_drop < 65535) m_drop++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_fifo_level", fifo_level, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
    check_eq("rst_busy", busy, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: ready always, 1: ready toggles, 2: ready random
  task automatic drain(input int mode, output int gaps);
    int n;
    n = 0;
    gaps = 0;
    vld_valid = 1'b0;
    while ((m_active || m_fifo.size() > 0) && n < 3000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = n[0];
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (!out_valid) gaps++;
      tick();
      n++;
    end
    check_eq("drain_idle", busy, 0);
  endtask

  logic [184:0] sf_snap;
  logic [7:0]   sf_exp[26];
  int           base, gaps, n;

  initial begin
    rst = 1'b1; trace_en = 1'b0; vld_valid = 1'b0; out_ready = 1'b0;
    set_snap('0);
    cyc = 0; frames_rx = 0;
    clear_model();
    @(negedge clk);
    do_reset();

    // single frame with latency check
    sf_snap = {5'h03, 4'h1, 32'h0, 16'h1234, 128'h0};
    for (int i = 0; i < 26; i++) sf_exp[i] = 8'h00;
    sf_exp[0] = 8'hA5; sf_exp[1] = 8'h03; sf_exp[2] = 8'h01;
    sf_exp[7] = 8'h34; sf_exp[8] = 8'h12; sf_exp[25] = 8'hB6;
    base = frames_rx;
    trace_en = 1'b1; out_ready = 1'b1; set_snap(sf_snap); vld_valid = 1'b1;
    tick();
    vld_valid = 1'b0;
    check_eq("lat_n1_valid", out_valid, 0);
    tick();
    check_eq("lat_n2_valid", out_valid, 1);
    check_eq("lat_n2_data", out_data, 8'hA5);
    drain(0, gaps);
    check_eq("sf_frames", frames_rx - base, 1);
    for (int i = 0; i < 26; i++) check_eq($sformatf("sf_byte%0d", i), rx_bytes[i], sf_exp[i]);

    // backpressure
    base = frames_rx;
    set_snap(sf_snap); vld_valid = 1'b1;
    tick();
    drain(1, gaps);
    check_eq("bp_frames", frames_rx - base, 1);
    for (int i = 0; i < 26; i++) check_eq($sformatf("bp_byte%0d", i), rx_bytes[i], sf_exp[i]);

    // overflow
    base = frames_rx;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_snap(rand_snap()); vld_valid = 1'b1;
      tick();
    end
    vld_valid = 1'b0;
    check_eq("ovf_drop", drop_cnt, 3);
    check_eq("ovf_level", fifo_level, 4);
    drain(0, gaps);
    check_eq("ovf_frames", frames_rx - base, 5);
    check_eq("ovf_gaps", gaps, 0);

    // enable gating
    do_reset();
    base = frames_rx;
    out_ready = 1'b1; trace_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_snap(rand_snap()); vld_valid = 1'b1;
      tick();
    end
    trace_en = 1'b1; set_snap(rand_snap());
    tick();
    drain(0, gaps);
    check_eq("en_frames", frames_rx - base, 1);
    check_eq("en_drop", drop_cnt, 0);

    // reset mid-frame
    for (int i = 0; i < 3; i++) begin
      set_snap(rand_snap()); vld_valid = 1'b1;
      tick();
    end
    vld_valid = 1'b0;
    n = 0;
    while (!(m_active && m_idx == 10) && n < 100) begin
      tick();
      n++;
    end
    check_eq("rmf_reached", out_valid && (m_idx == 10), 1);
    check_eq("rmf_level", fifo_level, 2);
    do_reset();
    base = frames_rx;
    set_snap(rand_snap()); vld_valid = 1'b1;
    tick();
    drain(0, gaps);
    check_eq("rmf_frames", frames_rx - base, 1);
    check_eq("rmf_first", rx_bytes[0], 8'hA5);

    // random sweep
    base = frames_rx;
    n = 0;
    while ((frames_rx - base) < 1000 && n < 60000) begin
      set_snap(rand_snap());
      vld_valid = ($urandom_range(0, 19) == 0);
      trace_en  = ($urandom_range(0, 15) != 0);
      out_ready = ($urandom_range(0, 9) != 0);
      tick();
      n++;
    end
    trace_en = 1'b1;
    drain(2, gaps);
    check_eq("sweep_done", (frames_rx - base) >= 1000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
